seven_seg_capture: RTL
======================

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples needed before a capture (legal range 2..255).
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port i_en, input, 1, meaning capture enable.
REQ-005 SHALL have port i_an, input, 4, meaning active-low digit anodes; i_an[k]=0 selects digit k.
REQ-006 SHALL have port i_seg, input, 7, meaning active-low segments, bit6=a through bit0=g.
REQ-007 SHALL have port o_digits, output, 16, meaning the last published frame; digit k is in bits [4k+3:4k].
REQ-008 SHALL have port o_blank, output, 4, meaning bit k is set when digit k was dark in the published frame.
REQ-009 SHALL have port o_frame_valid, output, 1, meaning a one-cycle pulse on publish.
REQ-010 SHALL have port o_seg_err, output, 1, meaning a one-cycle pulse when a captured pattern is unrecognized.
REQ-011 SHALL have port o_an_err, output, 1, meaning a one-cycle pulse on entry to a multi-hot anode value.

Function
REQ-012 SHALL register i_an and i_seg once (sample stage); all comparisons use the sampled values.
REQ-013 SHALL implement FSM states IDLE, SETTLE and HOLD.
- IDLE: no single anode is active.
- SETTLE: counting stable samples.
- HOLD: digit captured, waiting for the input to change.
REQ-014 SHALL go IDLE->SETTLE with count=1 when the sampled i_an has exactly one bit low.
REQ-015 SHALL, in SETTLE, increment count on an unchanged {an,seg} sample; on a changed sample it restarts count=1 if the new value is one-hot-low, otherwise it goes to IDLE.
REQ-016 SHALL assert a capture strobe in the cycle count reaches STABLE_CYCLES, then go to HOLD.
REQ-017 SHALL, in HOLD, go to SETTLE with count=1 on a changed one-hot sample, and to IDLE on any non-one-hot sample.
REQ-018 SHALL encode segments to hex on capture using the inverse of the team's decoder table:
- 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
- 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
REQ-019 SHALL, on capture of pattern 1111111, write shadow value 0 with shadow blank bit k set, and mark digit k captured.
REQ-020 SHALL, on capture of any other unlisted pattern, pulse o_seg_err the next cycle, leave the shadow and capture mask for digit k unchanged, and still enter HOLD.
REQ-021 SHALL, on a valid capture, write the shadow digit and blank bit for digit k and set capture-mask bit k.
REQ-022 SHALL publish in the cycle after the capture mask becomes 1111:
- shadow copied to o_digits and o_blank;
- o_frame_valid pulsed;
- mask cleared.
A capture arriving in the publish cycle lands in the next frame's mask.
REQ-023 SHALL pulse o_an_err the cycle after the sampled i_an becomes multi-hot-low (two or more zeros), and only on entry to that condition; i_an=1111 is not an error.
REQ-024 SHALL, when i_en=0, force IDLE, clear count and mask, and suppress all pulses; o_digits and o_blank hold.
REQ-025 SHALL register all outputs; o_digits and o_blank change only on publish.

Reset
REQ-026 SHALL set, on i_rst=1 at a clock edge:
- FSM=IDLE, count=0, mask=0, shadow=0;
- sample registers = 1111/1111111;
- o_digits=0, o_blank=1111, all pulses 0.
REQ-027 SHALL let reset take precedence over i_en; reset mid-SETTLE or mid-frame discards partial state with no pulse.

Structure
REQ-028 SHALL place the 16 segment-pattern constants, the BLANK pattern and the FSM state encoding in shared package seven_seg_pkg, which the existing decoder also uses.
REQ-029 SHALL implement segment-to-hex lookup as combinational sub-module seven_seg_encoder (i_seg[6:0] -> o_x[3:0], o_hit).

Verification
REQ-030 SHALL cover: i_an=1110, i_seg=0010010 held 4 cycles -> single capture of digit0=2, no pulses until the frame completes.
REQ-031 SHALL cover: drive digits 3,2,1,0 = F,0,A,5, each held 6 cycles -> exactly one o_frame_valid, o_digits=16'hF0A5, o_blank=0000.
REQ-032 SHALL cover: i_seg toggling every 3 cycles with STABLE_CYCLES=4 -> no capture, no pulses.
REQ-033 SHALL cover: digit2 driven 1111111, others valid -> o_blank=0100, o_digits[11:8]=0.
REQ-034 SHALL cover: i_seg=1010101 held 4 cycles -> one o_seg_err pulse, mask unchanged; i_an=1100 -> one o_an_err pulse.
REQ-035 SHALL cover: i_rst after 3 digits captured, then 4 new digits -> exactly one frame containing only the new values.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants, FSM encoding and anode helpers for the
// capture block and the display decoder.
package seven_seg_pkg;

  // Active-low segment patterns, bit6 = a through bit0 = g.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  function automatic logic an_one_hot(input logic [3:0] an);
    return $onehot(~an);
  endfunction

  function automatic logic an_multi_hot(input logic [3:0] an);
    return $countones(~an) > 1;
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] k;
    k = 2'd0;
    case (an)
      4'b1110: k = 2'd0;
      4'b1101: k = 2'd1;
      4'b1011: k = 2'd2;
      4'b0111: k = 2'd3;
      default: k = 2'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational segment-pattern to hex lookup; o_hit is low for any
// pattern outside the sixteen digit glyphs (including blank).
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_x,
  output logic       o_hit
);

  always_comb begin
    o_x   = '0;
    o_hit = 1'b1;
    case (i_seg)
      SEG_0:   o_x = 4'h0;
      SEG_1:   o_x = 4'h1;
      SEG_2:   o_x = 4'h2;
      SEG_3:   o_x = 4'h3;
      SEG_4:   o_x = 4'h4;
      SEG_5:   o_x = 4'h5;
      SEG_6:   o_x = 4'h6;
      SEG_7:   o_x = 4'h7;
      SEG_8:   o_x = 4'h8;
      SEG_9:   o_x = 4'h9;
      SEG_A:   o_x = 4'hA;
      SEG_B:   o_x = 4'hB;
      SEG_C:   o_x = 4'hC;
      SEG_D:   o_x = 4'hD;
      SEG_E:   o_x = 4'hE;
      SEG_F:   o_x = 4'hF;
      default: o_hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the four hex digits shown on a multiplexed active-low seven-segment
// bus and publishes them as a frame once every digit has been captured.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [3:0]  i_an,
  input  logic [6:0]  i_seg,
  output logic [15:0] o_digits,
  output logic [3:0]  o_blank,
  output logic        o_frame_valid,
  output logic        o_seg_err,
  output logic        o_an_err
);

  logic [3:0]  an_s;
  logic [6:0]  seg_s;
  logic [3:0]  ref_an;
  logic [6:0]  ref_seg;
  state_t      state, state_next;
  logic [7:0]  count, count_next;
  logic        load_ref;
  logic        capture;
  logic        changed;
  logic        one_hot;
  logic        multi_q;
  logic [3:0]  mask;
  logic [15:0] shadow_d;
  logic [3:0]  shadow_b;

  logic [3:0]  enc_x;
  logic        enc_hit;
  logic [1:0]  dig_k;
  logic        is_blank;
  logic        cap_ok;
  logic [3:0]  cap_bit;
  logic        publish;

  seven_seg_encoder u_encoder (
    .i_seg (seg_s),
    .o_x   (enc_x),
    .o_hit (enc_hit)
  );

  assign changed  = {an_s, seg_s} != {ref_an, ref_seg};
  assign one_hot  = an_one_hot(an_s);
  assign dig_k    = an_index(an_s);
  assign is_blank = (seg_s == SEG_BLANK);
  assign cap_ok   = capture & (enc_hit | is_blank);
  assign cap_bit  = cap_ok ? (4'b0001 << dig_k) : '0;
  assign publish  = i_en & (mask == '1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // ref_* holds the sample being tracked; in SETTLE it always equals the
  // previous sample, so comparing against it is the "unchanged" test.
  always_comb begin
    state_next = state;
    count_next = count;
    load_ref   = 1'b0;
    capture    = 1'b0;
    if (!i_en) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (one_hot) begin
            state_next = ST_SETTLE;
            count_next = 8'd1;
            load_ref   = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!changed) begin
            count_next = count + 8'd1;
            if (count == 8'(STABLE_CYCLES - 1)) begin
              capture    = 1'b1;
              state_next = ST_HOLD;
            end
          end else if (one_hot) begin
            count_next = 8'd1;
            load_ref   = 1'b1;
          end else begin
            state_next = ST_IDLE;
            count_next = '0;
          end
        end
        ST_HOLD: begin
          if (!one_hot) begin
            state_next = ST_IDLE;
            count_next = '0;
          end else if (changed) begin
            state_next = ST_SETTLE;
            count_next = 8'd1;
            load_ref   = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_s          <= '1;
      seg_s         <= '1;
      ref_an        <= '1;
      ref_seg       <= '1;
      multi_q       <= 1'b0;
      mask          <= '0;
      shadow_d      <= '0;
      shadow_b      <= '0;
      o_digits      <= '0;
      o_blank       <= '1;
      o_frame_valid <= 1'b0;
      o_seg_err     <= 1'b0;
      o_an_err      <= 1'b0;
    end else begin
      an_s          <= i_an;
      seg_s         <= i_seg;
      multi_q       <= an_multi_hot(an_s);
      o_frame_valid <= publish;
      o_seg_err     <= capture & ~enc_hit & ~is_blank;
      o_an_err      <= i_en & an_multi_hot(an_s) & ~multi_q;
      if (load_ref) begin
        ref_an  <= an_s;
        ref_seg <= seg_s;
      end
      if (publish) begin
        o_digits <= shadow_d;
        o_blank  <= shadow_b;
      end
      // A capture in the publish cycle seeds the next frame's mask.
      if (!i_en) mask <= '0;
      else       mask <= (publish ? 4'b0000 : mask) | cap_bit;
      if (cap_ok) begin
        shadow_d[{dig_k, 2'b00} +: 4] <= is_blank ? 4'h0 : enc_x;
        shadow_b[dig_k]               <= is_blank;
      end
    end
  end

endmodule
